// File: rtl/dds_sched_pkg.sv
// Shared types and default widths for the DDS parameter scheduler.
// The command struct is sized from the package constants. The scheduler's
// width parameters must therefore keep their default values whenever this
// struct carries the commands.
package dds_sched_pkg;

  localparam int DDS_DEPTH  = 8;
  localparam int DDS_TS_W   = 48;
  localparam int DDS_FREQ_W = 48;
  localparam int DDS_PH_W   = 14;

  // One timestamped parameter command. 'sync' selects whether the fire time
  // is loaded into the timeoffset register.
  typedef struct packed {
    logic [DDS_TS_W-1:0]   ftime;
    logic [DDS_FREQ_W-1:0] freq;
    logic [DDS_PH_W-1:0]   phase;
    logic                  sync;
  } dds_cmd_t;

endpackage

// File: rtl/dds_cmd_fifo.sv
// Synchronous command FIFO with a prefetched head register.
// The oldest command always sits in head_q when head_valid_o is set, so the
// consumer can compare its time combinationally every cycle. The remaining
// commands wait in a circular buffer behind the head.
//
// Ports:
//   clk, resetn   clock, synchronous active-low reset (control state only)
//   flush_i       empty the FIFO on the next edge; a same-cycle push is dropped
//   push_i        write push_data_i (the caller guarantees ready_o)
//   push_data_i   command to enqueue
//   pop_i         consume the head (the caller guarantees head_valid_o)
//   ready_o       occupancy below DEPTH
//   head_valid_o  head_o holds the oldest command
//   head_o        oldest command
//   level_o       total occupancy, including the head
module dds_cmd_fifo
  import dds_sched_pkg::*;
#(
  parameter int DEPTH = DDS_DEPTH
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  dds_cmd_t               push_data_i,
  input  logic                   pop_i,
  output logic                   ready_o,
  output logic                   head_valid_o,
  output dds_cmd_t               head_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  dds_cmd_t             mem_q [DEPTH];
  dds_cmd_t             head_q;
  logic                 head_valid_q, head_valid_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     mem_cnt_q, mem_cnt_d;
  logic [LVL_W-1:0]     level;
  logic                 push_ok, head_take, mem_rd, bypass, mem_wr;

  always_comb begin
    push_ok   = push_i && !flush_i;
    // The head slot is free this cycle if it is empty or being consumed.
    head_take = !head_valid_q || pop_i;
    mem_rd    = head_take && (mem_cnt_q != '0);
    // Push into an empty buffer with a free head slot goes straight to the head.
    bypass    = head_take && (mem_cnt_q == '0) && push_ok;
    mem_wr    = push_ok && !bypass;

    wr_ptr_d     = wr_ptr_q + AW'(mem_wr);
    rd_ptr_d     = rd_ptr_q + AW'(mem_rd);
    mem_cnt_d    = mem_cnt_q + LVL_W'(mem_wr) - LVL_W'(mem_rd);
    head_valid_d = head_take ? (mem_rd || bypass) : 1'b1;

    if (flush_i) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      mem_cnt_d    = '0;
      head_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_cnt_q    <= '0;
      head_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_cnt_q    <= mem_cnt_d;
      head_valid_q <= head_valid_d;
    end
  end

  // Payload storage is qualified by the control state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (!flush_i) begin
      if (mem_wr) mem_q[wr_ptr_q] <= push_data_i;
      if (mem_rd) head_q <= mem_q[rd_ptr_q];
      else if (bypass) head_q <= push_data_i;
    end
  end

  assign level        = LVL_W'(head_valid_q) + mem_cnt_q;
  assign level_o      = level;
  assign ready_o      = level < LVL_W'(DEPTH);
  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/dds_param_scheduler.sv
// Timestamped parameter writer for the DDS phase datapath.
// This block owns the free-running timestamp and buffers commands in a FIFO.
// When a command's time has been reached, it applies the command's
// timeoffset, frequency and phase together on one edge.
//
// Ports:
//   clk, resetn      clock, synchronous active-low reset
//   run              timestamp counts and commands may fire
//   flush            empty the FIFO and clear late_err (outputs retained)
//   cmd_valid/ready  command handshake; cmd_ready = level < DEPTH
//   cmd_time/freq/phase/sync  command payload
//   timestamp        current time
//   timeoffset/freq/phase     applied parameters
//   upd              one-cycle pulse when new parameters first appear
//   late_err         sticky: a command fired after its time
//   level            FIFO occupancy
module dds_param_scheduler
  import dds_sched_pkg::*;
#(
  parameter int DEPTH  = DDS_DEPTH,
  parameter int TS_W   = DDS_TS_W,
  parameter int FREQ_W = DDS_FREQ_W,
  parameter int PH_W   = DDS_PH_W
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   run,
  input  logic                   flush,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [TS_W-1:0]        cmd_time,
  input  logic [FREQ_W-1:0]      cmd_freq,
  input  logic [PH_W-1:0]        cmd_phase,
  input  logic                   cmd_sync,
  output logic [TS_W-1:0]        timestamp,
  output logic [TS_W-1:0]        timeoffset,
  output logic [FREQ_W-1:0]      freq,
  output logic [PH_W-1:0]        phase,
  output logic                   upd,
  output logic                   late_err,
  output logic [$clog2(DEPTH):0] level
);

  dds_cmd_t            push_cmd, head;
  logic                head_valid, push, fire;

  logic [TS_W-1:0]     ts_q, ts_d;
  logic [TS_W-1:0]     off_q, off_d;
  logic [FREQ_W-1:0]   freq_q, freq_d;
  logic [PH_W-1:0]     ph_q, ph_d;
  logic                upd_q, upd_d;
  logic                late_q, late_d;

  assign push_cmd = '{ftime: cmd_time, freq: cmd_freq, phase: cmd_phase, sync: cmd_sync};
  assign push     = cmd_valid && cmd_ready;

  dds_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush),
    .push_i       (push),
    .push_data_i  (push_cmd),
    .pop_i        (fire),
    .ready_o      (cmd_ready),
    .head_valid_o (head_valid),
    .head_o       (head),
    .level_o      (level)
  );

  // Head compare stage: decide this cycle, apply on the next edge.
  always_comb begin
    // Plain unsigned compare. Times behind a wrap are treated as due.
    fire   = head_valid && run && (head.ftime <= ts_q);
    ts_d   = run ? ts_q + TS_W'(1) : ts_q;
    // Load the command time, not the current timestamp, so a late command
    // still lands phase-coherently.
    off_d  = (fire && head.sync) ? head.ftime : off_q;
    freq_d = fire ? head.freq : freq_q;
    ph_d   = fire ? head.phase : ph_q;
    upd_d  = fire;
    // A fire during flush still updates the outputs, but it is never flagged.
    late_d = flush ? 1'b0 : (late_q || (fire && (head.ftime < ts_q)));
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ts_q   <= '0;
      off_q  <= '0;
      freq_q <= '0;
      ph_q   <= '0;
      upd_q  <= 1'b0;
      late_q <= 1'b0;
    end else begin
      ts_q   <= ts_d;
      off_q  <= off_d;
      freq_q <= freq_d;
      ph_q   <= ph_d;
      upd_q  <= upd_d;
      late_q <= late_d;
    end
  end

  assign timestamp  = ts_q;
  assign timeoffset = off_q;
  assign freq       = freq_q;
  assign phase      = ph_q;
  assign upd        = upd_q;
  assign late_err   = late_q;

endmodule

// File: tb/tb_dds_param_scheduler.sv
module tb_dds_param_scheduler;

  logic        clk = 1'b0;
  logic        resetn, run, flush, cmd_valid, cmd_ready, cmd_sync;
  logic [47:0] cmd_time, cmd_freq;
  logic [13:0] cmd_phase;
  logic [47:0] timestamp, timeoffset, freq;
  logic [13:0] phase;
  logic        upd, late_err;
  logic [3:0]  level;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dds_param_scheduler dut (
    .clk        (clk),
    .resetn     (resetn),
    .run        (run),
    .flush      (flush),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_time   (cmd_time),
    .cmd_freq   (cmd_freq),
    .cmd_phase  (cmd_phase),
    .cmd_sync   (cmd_sync),
    .timestamp  (timestamp),
    .timeoffset (timeoffset),
    .freq       (freq),
    .phase      (phase),
    .upd        (upd),
    .late_err   (late_err),
    .level      (level)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    resetn = 1'b0; run = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    step; step;
    resetn = 1'b1;
  endtask

  task automatic drive(input logic [47:0] t, input logic [47:0] f,
                       input logic [13:0] p, input logic s);
    cmd_time = t; cmd_freq = f; cmd_phase = p; cmd_sync = s; cmd_valid = 1'b1;
  endtask

  task automatic test_reset;
    do_reset;
    total++; if (timestamp !== 48'd0) begin $display("FAIL reset_ts got=%0h want=0", timestamp); bad++; end
    total++; if (timeoffset !== 48'd0) begin $display("FAIL reset_off got=%0h want=0", timeoffset); bad++; end
    total++; if (freq !== 48'd0) begin $display("FAIL reset_freq got=%0h want=0", freq); bad++; end
    total++; if (phase !== 14'd0) begin $display("FAIL reset_phase got=%0h want=0", phase); bad++; end
    total++; if (upd !== 1'b0) begin $display("FAIL reset_upd got=%0b want=0", upd); bad++; end
    total++; if (late_err !== 1'b0) begin $display("FAIL reset_late got=%0b want=0", late_err); bad++; end
    total++; if (level !== 4'd0) begin $display("FAIL reset_level got=%0d want=0", level); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL reset_ready got=%0b want=1", cmd_ready); bad++; end
    step;
    total++; if (timestamp !== 48'd0) begin $display("FAIL hold_ts got=%0h want=0", timestamp); bad++; end
  endtask

  task automatic test_basic;
    int n = 0;
    logic [47:0] upd_ts = '0;
    run = 1'b1;
    drive(48'd20, 48'h1000, 14'h155, 1'b1);
    step;
    cmd_valid = 1'b0;
    total++; if (level !== 4'd1) begin $display("FAIL basic_level got=%0d want=1", level); bad++; end
    for (int i = 0; i < 40; i++) begin
      step;
      if (upd) begin n++; upd_ts = timestamp; end
    end
    total++; if (n !== 1) begin $display("FAIL basic_count got=%0d want=1", n); bad++; end
    total++; if (upd_ts !== 48'd21) begin $display("FAIL basic_upd_ts got=%0d want=21", upd_ts); bad++; end
    total++; if (timeoffset !== 48'd20) begin $display("FAIL basic_off got=%0h want=14", timeoffset); bad++; end
    total++; if (freq !== 48'h1000) begin $display("FAIL basic_freq got=%0h want=1000", freq); bad++; end
    total++; if (phase !== 14'h155) begin $display("FAIL basic_phase got=%0h want=155", phase); bad++; end
    total++; if (late_err !== 1'b0) begin $display("FAIL basic_late got=%0b want=0", late_err); bad++; end
  endtask

  task automatic test_late;
    for (int i = 0; i < 200 && timestamp != 48'd100; i++) step;
    total++; if (timestamp !== 48'd100) begin $display("FAIL late_wait_ts got=%0d want=100", timestamp); bad++; end
    drive(48'd50, 48'h777, 14'h22, 1'b1);
    step;
    cmd_valid = 1'b0;
    total++; if (upd !== 1'b0) begin $display("FAIL late_upd_early got=%0b want=0", upd); bad++; end
    total++; if (level !== 4'd1) begin $display("FAIL late_level got=%0d want=1", level); bad++; end
    step;
    total++; if (upd !== 1'b1) begin $display("FAIL late_upd got=%0b want=1", upd); bad++; end
    total++; if (timeoffset !== 48'd50) begin $display("FAIL late_off got=%0d want=50", timeoffset); bad++; end
    total++; if (freq !== 48'h777) begin $display("FAIL late_freq got=%0h want=777", freq); bad++; end
    total++; if (late_err !== 1'b1) begin $display("FAIL late_flag got=%0b want=1", late_err); bad++; end
    total++; if (level !== 4'd0) begin $display("FAIL late_level_after got=%0d want=0", level); bad++; end
    step; step;
    total++; if (upd !== 1'b0) begin $display("FAIL late_upd_pulse got=%0b want=0", upd); bad++; end
    total++; if (late_err !== 1'b1) begin $display("FAIL late_sticky got=%0b want=1", late_err); bad++; end
    flush = 1'b1;
    step;
    flush = 1'b0;
    total++; if (late_err !== 1'b0) begin $display("FAIL flush_clears_late got=%0b want=0", late_err); bad++; end
    total++; if (freq !== 48'h777) begin $display("FAIL flush_keeps_freq got=%0h want=777", freq); bad++; end
    total++; if (timeoffset !== 48'd50) begin $display("FAIL flush_keeps_off got=%0d want=50", timeoffset); bad++; end
  endtask

  task automatic test_ordering;
    int  n = 0;
    logic pushing;
    do_reset;
    for (int i = 0; i < 8; i++) begin
      total++; if (cmd_ready !== 1'b1) begin $display("FAIL order_ready_%0d got=%0b want=1", i, cmd_ready); bad++; end
      drive(48'(10 + i), 48'('h100 + i), 14'(i), 1'b0);
      step;
    end
    drive(48'd18, 48'h108, 14'd8, 1'b0);
    total++; if (level !== 4'd8) begin $display("FAIL order_level_full got=%0d want=8", level); bad++; end
    total++; if (cmd_ready !== 1'b0) begin $display("FAIL order_ready_full got=%0b want=0", cmd_ready); bad++; end
    step; step;
    total++; if (level !== 4'd8) begin $display("FAIL order_level_held got=%0d want=8", level); bad++; end
    run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      pushing = cmd_valid && cmd_ready;
      step;
      if (pushing) cmd_valid = 1'b0;
      if (upd) begin
        total++; if (timestamp !== 48'(11 + n)) begin $display("FAIL order_ts_%0d got=%0d want=%0d", n, timestamp, 11 + n); bad++; end
        total++; if (freq !== 48'('h100 + n)) begin $display("FAIL order_freq_%0d got=%0h want=%0h", n, freq, 'h100 + n); bad++; end
        n++;
      end
    end
    total++; if (n !== 9) begin $display("FAIL order_count got=%0d want=9", n); bad++; end
    total++; if (cmd_valid !== 1'b0) begin $display("FAIL order_ninth_accepted got=%0b want=0", cmd_valid); bad++; end
    total++; if (late_err !== 1'b0) begin $display("FAIL order_late got=%0b want=0", late_err); bad++; end
    total++; if (timeoffset !== 48'd0) begin $display("FAIL order_off got=%0d want=0", timeoffset); bad++; end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    do_reset;
    drive(48'd40, 48'hA, 14'd1, 1'b1); step;
    drive(48'd40, 48'hB, 14'd2, 1'b1); step;
    drive(48'd40, 48'hC, 14'd3, 1'b1); step;
    cmd_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step;
      if (upd) begin
        total++; if (timestamp !== 48'(41 + n)) begin $display("FAIL burst_ts_%0d got=%0d want=%0d", n, timestamp, 41 + n); bad++; end
        if (n == 0) begin
          total++; if (late_err !== 1'b0) begin $display("FAIL burst_first_late got=%0b want=0", late_err); bad++; end
        end
        n++;
      end
    end
    total++; if (n !== 3) begin $display("FAIL burst_count got=%0d want=3", n); bad++; end
    total++; if (freq !== 48'hC) begin $display("FAIL burst_freq got=%0h want=c", freq); bad++; end
    total++; if (phase !== 14'd3) begin $display("FAIL burst_phase got=%0h want=3", phase); bad++; end
    total++; if (timeoffset !== 48'd40) begin $display("FAIL burst_off got=%0d want=40", timeoffset); bad++; end
    total++; if (late_err !== 1'b1) begin $display("FAIL burst_late got=%0b want=1", late_err); bad++; end
  endtask

  task automatic test_sync0;
    int n = 0;
    do_reset;
    drive(48'd10, 48'h1, 14'h11, 1'b1); step;
    drive(48'd30, 48'h2, 14'h22, 1'b0); step;
    cmd_valid = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step;
      if (upd) n++;
    end
    total++; if (n !== 2) begin $display("FAIL sync0_count got=%0d want=2", n); bad++; end
    total++; if (timeoffset !== 48'd10) begin $display("FAIL sync0_off got=%0d want=10", timeoffset); bad++; end
    total++; if (freq !== 48'h2) begin $display("FAIL sync0_freq got=%0h want=2", freq); bad++; end
    total++; if (phase !== 14'h22) begin $display("FAIL sync0_phase got=%0h want=22", phase); bad++; end
    total++; if (late_err !== 1'b0) begin $display("FAIL sync0_late got=%0b want=0", late_err); bad++; end
  endtask

  task automatic test_flush;
    int n = 0;
    for (int i = 0; i < 4; i++) begin
      drive(48'd1000, 48'h55, 14'h5, 1'b1);
      step;
    end
    cmd_valid = 1'b0;
    total++; if (level !== 4'd4) begin $display("FAIL flush_level_before got=%0d want=4", level); bad++; end
    flush = 1'b1;
    drive(48'd1000, 48'h66, 14'h6, 1'b1);
    step;
    flush = 1'b0;
    cmd_valid = 1'b0;
    total++; if (level !== 4'd0) begin $display("FAIL flush_level got=%0d want=0", level); bad++; end
    total++; if (cmd_ready !== 1'b1) begin $display("FAIL flush_ready got=%0b want=1", cmd_ready); bad++; end
    for (int i = 0; i < 30; i++) begin
      step;
      if (upd) n++;
    end
    total++; if (n !== 0) begin $display("FAIL flush_no_upd got=%0d want=0", n); bad++; end
    total++; if (freq !== 48'h2) begin $display("FAIL flush_freq got=%0h want=2", freq); bad++; end
    total++; if (timeoffset !== 48'd10) begin $display("FAIL flush_off got=%0d want=10", timeoffset); bad++; end
  endtask

  task automatic test_flush_fire;
    do_reset;
    run = 1'b1;
    for (int i = 0; i < 10; i++) step;
    run = 1'b0;
    drive(48'd3, 48'h99, 14'h33, 1'b1);
    step;
    cmd_valid = 1'b0;
    total++; if (level !== 4'd1) begin $display("FAIL ffire_level got=%0d want=1", level); bad++; end
    total++; if (upd !== 1'b0) begin $display("FAIL ffire_frozen got=%0b want=0", upd); bad++; end
    run = 1'b1;
    flush = 1'b1;
    step;
    flush = 1'b0;
    total++; if (upd !== 1'b1) begin $display("FAIL ffire_upd got=%0b want=1", upd); bad++; end
    total++; if (freq !== 48'h99) begin $display("FAIL ffire_freq got=%0h want=99", freq); bad++; end
    total++; if (timeoffset !== 48'd3) begin $display("FAIL ffire_off got=%0d want=3", timeoffset); bad++; end
    total++; if (late_err !== 1'b0) begin $display("FAIL ffire_late got=%0b want=0", late_err); bad++; end
    total++; if (level !== 4'd0) begin $display("FAIL ffire_level_after got=%0d want=0", level); bad++; end
    total++; if (timestamp !== 48'd11) begin $display("FAIL ffire_ts got=%0d want=11", timestamp); bad++; end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    run = 1'b0;
    drive(48'd5, 48'hAA, 14'h1, 1'b1); step;
    drive(48'd6, 48'hBB, 14'h2, 1'b1); step;
    cmd_valid = 1'b0;
    total++; if (level !== 4'd2) begin $display("FAIL rmid_level_before got=%0d want=2", level); bad++; end
    resetn = 1'b0;
    step;
    total++; if (timestamp !== 48'd0) begin $display("FAIL rmid_ts got=%0d want=0", timestamp); bad++; end
    total++; if (freq !== 48'd0) begin $display("FAIL rmid_freq got=%0h want=0", freq); bad++; end
    total++; if (timeoffset !== 48'd0) begin $display("FAIL rmid_off got=%0h want=0", timeoffset); bad++; end
    total++; if (phase !== 14'd0) begin $display("FAIL rmid_phase got=%0h want=0", phase); bad++; end
    total++; if (level !== 4'd0) begin $display("FAIL rmid_level got=%0d want=0", level); bad++; end
    resetn = 1'b1;
    run = 1'b1;
    step;
    total++; if (timestamp !== 48'd1) begin $display("FAIL rmid_restart got=%0d want=1", timestamp); bad++; end
    for (int i = 0; i < 20; i++) begin
      step;
      if (upd) n++;
    end
    total++; if (n !== 0) begin $display("FAIL rmid_no_upd got=%0d want=0", n); bad++; end
    total++; if (freq !== 48'd0) begin $display("FAIL rmid_freq_after got=%0h want=0", freq); bad++; end
  endtask

  initial begin
    resetn = 1'b0; run = 1'b0; flush = 1'b0; cmd_valid = 1'b0;
    cmd_time = '0; cmd_freq = '0; cmd_phase = '0; cmd_sync = 1'b0;
    test_reset;
    test_basic;
    test_late;
    test_ordering;
    test_back_to_back;
    test_sync0;
    test_flush;
    test_flush_fire;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
